// File: rtl/ets_instr_monitor.sv
// rtl/ets_instr_monitor.sv - ETS instruction-timing producer: issue/retire to start/active/done pulses
module ets_instr_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        monitor_en,
  input  logic        issue_valid,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_instr,
  input  logic        retire_valid,
  input  logic        flush,
  output logic        instr_start,
  output logic        instr_active,
  output logic        instr_done,
  output logic        instr_abort,
  output logic        instr_timeout,
  output logic [31:0] mon_pc,
  output logic [6:0]  mon_opcode,
  output logic [2:0]  mon_class,
  output logic        err_overlap,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // RV32IM class decode; OP-IMM is always ALU, only OP with funct7=0000001 is MULDIV
  function automatic logic [2:0] f_decode(input logic [31:0] instr);
    logic [2:0] cls;
    case (instr[6:0])
      7'b0110011: cls = (instr[31:25] == 7'b0000001) ? 3'd5 : 3'd0;
      7'b0010011: cls = 3'd0;
      7'b0000011: cls = 3'd1;
      7'b0100011: cls = 3'd2;
      7'b1100011: cls = 3'd3;
      7'b1101111,
      7'b1100111: cls = 3'd4;
      7'b1110011: cls = 3'd6;
      default:    cls = 3'd7;
    endcase
    return cls;
  endfunction

  state_t      r_state, w_nxt_state;
  logic [TO_W-1:0] r_to_cnt, w_nxt_cnt;
  logic        r_retire_seen, w_nxt_retire_seen;
  logic        r_pend_valid, w_nxt_pend_valid;
  logic [31:0] r_pend_pc, w_nxt_pend_pc;
  logic [31:0] r_pend_instr, w_nxt_pend_instr;

  logic        r_start, w_nxt_start;
  logic        r_active, w_nxt_active;
  logic        r_done, w_nxt_done;
  logic        r_abort, w_nxt_abort;
  logic        r_timeout, w_nxt_timeout;
  logic [31:0] r_pc, w_nxt_pc;
  logic [6:0]  r_opcode, w_nxt_opcode;
  logic [2:0]  r_class, w_nxt_class;
  logic        r_err, w_nxt_err;
  logic        r_busy, w_nxt_busy;

  logic        w_issue;
  logic        w_retire;
  logic        w_to_hit;
  logic [31:0] w_src_pc;
  logic [31:0] w_src_instr;

  assign w_issue     = issue_valid & monitor_en;
  // A retire that arrived together with the issue is remembered and honoured in the first ACTIVE cycle
  assign w_retire    = retire_valid | r_retire_seen;
  assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // A pending instruction always wins the next start slot over a fresh issue
  assign w_src_pc    = r_pend_valid ? r_pend_pc : issue_pc;
  assign w_src_instr = r_pend_valid ? r_pend_instr : issue_instr;

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = r_to_cnt;
    w_nxt_retire_seen = r_retire_seen;
    w_nxt_pend_valid  = r_pend_valid;
    w_nxt_pend_pc     = r_pend_pc;
    w_nxt_pend_instr  = r_pend_instr;
    w_nxt_start       = 1'b0;
    w_nxt_active      = 1'b0;
    w_nxt_done        = 1'b0;
    w_nxt_abort       = 1'b0;
    w_nxt_timeout     = 1'b0;
    w_nxt_pc          = r_pc;
    w_nxt_opcode      = r_opcode;
    w_nxt_class       = r_class;
    w_nxt_err         = r_err;
    case (r_state)
      S_ACTIVE: begin
        if (flush) begin
          w_nxt_state       = S_DONE;
          w_nxt_done        = 1'b1;
          w_nxt_abort       = 1'b1;
          w_nxt_retire_seen = 1'b0;
          w_nxt_pend_valid  = 1'b0;
        end else if (w_retire) begin
          w_nxt_state       = S_DONE;
          w_nxt_done        = 1'b1;
          w_nxt_retire_seen = 1'b0;
          if (w_issue) begin
            w_nxt_pend_valid = 1'b1;
            w_nxt_pend_pc    = issue_pc;
            w_nxt_pend_instr = issue_instr;
          end
        end else if (w_to_hit) begin
          w_nxt_state   = S_DONE;
          w_nxt_done    = 1'b1;
          w_nxt_timeout = 1'b1;
          if (w_issue) w_nxt_err = 1'b1;
        end else begin
          w_nxt_active = 1'b1;
          w_nxt_cnt    = r_to_cnt + 1'b1;
          if (w_issue) w_nxt_err = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new start; DONE only differs by possibly holding a pending
        w_nxt_state = S_IDLE;
        if (flush) begin
          w_nxt_pend_valid = 1'b0;
        end else if (r_pend_valid || w_issue) begin
          w_nxt_state       = S_ACTIVE;
          w_nxt_start       = 1'b1;
          w_nxt_active      = 1'b1;
          w_nxt_cnt         = '0;
          w_nxt_retire_seen = retire_valid;
          w_nxt_pend_valid  = 1'b0;
          w_nxt_pc          = w_src_pc;
          w_nxt_opcode      = w_src_instr[6:0];
          w_nxt_class       = f_decode(w_src_instr);
          if (r_pend_valid && w_issue) w_nxt_err = 1'b1;
        end
      end
    endcase
    w_nxt_busy = (w_nxt_state != S_IDLE) | w_nxt_pend_valid;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_retire_seen <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_pc     <= '0;
      r_pend_instr  <= '0;
      r_start       <= 1'b0;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
      r_abort       <= 1'b0;
      r_timeout     <= 1'b0;
      r_pc          <= '0;
      r_opcode      <= '0;
      r_class       <= '0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_to_cnt      <= w_nxt_cnt;
      r_retire_seen <= w_nxt_retire_seen;
      r_pend_valid  <= w_nxt_pend_valid;
      r_pend_pc     <= w_nxt_pend_pc;
      r_pend_instr  <= w_nxt_pend_instr;
      r_start       <= w_nxt_start;
      r_active      <= w_nxt_active;
      r_done        <= w_nxt_done;
      r_abort       <= w_nxt_abort;
      r_timeout     <= w_nxt_timeout;
      r_pc          <= w_nxt_pc;
      r_opcode      <= w_nxt_opcode;
      r_class       <= w_nxt_class;
      r_err         <= w_nxt_err;
      r_busy        <= w_nxt_busy;
    end
  end

  assign instr_start   = r_start;
  assign instr_active  = r_active;
  assign instr_done    = r_done;
  assign instr_abort   = r_abort;
  assign instr_timeout = r_timeout;
  assign mon_pc        = r_pc;
  assign mon_opcode    = r_opcode;
  assign mon_class     = r_class;
  assign err_overlap   = r_err;
  assign busy          = r_busy;

endmodule

// File: tb/tb_ets_instr_monitor.sv
// tb/tb_ets_instr_monitor.sv - scoreboard bench for ets_instr_monitor with a reference model
module tb_ets_instr_monitor;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        monitor_en = 1'b0;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_pc = '0;
  logic [31:0] issue_instr = '0;
  logic        retire_valid = 1'b0;
  logic        flush = 1'b0;
  logic        instr_start, instr_active, instr_done, instr_abort, instr_timeout;
  logic [31:0] mon_pc;
  logic [6:0]  mon_opcode;
  logic [2:0]  mon_class;
  logic        err_overlap, busy;

  ets_instr_monitor #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .monitor_en(monitor_en), .issue_valid(issue_valid),
    .issue_pc(issue_pc), .issue_instr(issue_instr), .retire_valid(retire_valid),
    .flush(flush), .instr_start(instr_start), .instr_active(instr_active),
    .instr_done(instr_done), .instr_abort(instr_abort), .instr_timeout(instr_timeout),
    .mon_pc(mon_pc), .mon_opcode(mon_opcode), .mon_class(mon_class),
    .err_overlap(err_overlap), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [41:0] mon;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: instruction-level bookkeeping
  bit        m_run, m_fin, m_ret, m_err;
  int        m_age;
  bit [31:0] m_pq_pc[$];
  bit [31:0] m_pq_in[$];
  bit [31:0] m_pc;
  bit [6:0]  m_op;
  bit [2:0]  m_cls;

  function automatic bit [2:0] ref_class(bit [31:0] w);
    bit [6:0] op;
    bit       m;
    op = w[6:0];
    m  = (w[31:25] == 7'b0000001);
    if (op == 7'h33) return m ? 3'd5 : 3'd0;
    if (op == 7'h13) return 3'd0;
    if (op == 7'h03) return 3'd1;
    if (op == 7'h23) return 3'd2;
    if (op == 7'h63) return 3'd3;
    if (op == 7'h6f || op == 7'h67) return 3'd4;
    if (op == 7'h73) return 3'd6;
    return 3'd7;
  endfunction

  task automatic cyc(input bit rst, input bit en, input bit iv, input bit [31:0] pc,
                     input bit [31:0] ins, input bit rv, input bit fl);
    exp_t      e;
    bit        iss, st, ac, dn, ab, to;
    bit [31:0] s_pc, s_in;
    st = 0; ac = 0; dn = 0; ab = 0; to = 0; s_pc = 0; s_in = 0;
    rst_n = rst; monitor_en = en; issue_valid = iv; issue_pc = pc;
    issue_instr = ins; retire_valid = rv; flush = fl;
    iss = iv && en;
    if (!rst) begin
      m_run = 0; m_fin = 0; m_ret = 0; m_err = 0; m_age = 0;
      m_pq_pc.delete(); m_pq_in.delete();
      m_pc = 0; m_op = 0; m_cls = 0;
    end else if (m_run) begin
      if (fl) begin
        dn = 1; ab = 1; m_run = 0; m_fin = 1;
        m_pq_pc.delete(); m_pq_in.delete();
      end else if (rv || m_ret) begin
        dn = 1; m_run = 0; m_fin = 1;
        if (iss) begin m_pq_pc.push_back(pc); m_pq_in.push_back(ins); end
      end else if (m_age == TO) begin
        dn = 1; to = 1; m_run = 0; m_fin = 1;
        if (iss) m_err = 1;
      end else begin
        ac = 1; m_age++;
        if (iss) m_err = 1;
      end
    end else begin
      m_fin = 0;
      if (fl) begin
        m_pq_pc.delete(); m_pq_in.delete();
      end else if (m_pq_pc.size() > 0) begin
        s_pc = m_pq_pc.pop_front(); s_in = m_pq_in.pop_front(); st = 1;
        if (iss) m_err = 1;
      end else if (iss) begin
        s_pc = pc; s_in = ins; st = 1;
      end
      if (st) begin
        ac = 1; m_run = 1; m_age = 1; m_ret = rv;
        m_pc = s_pc; m_op = s_in[6:0]; m_cls = ref_class(s_in);
      end
    end
    e.ctl = {st, ac, dn, ab, to, m_err, (m_run || m_fin || m_pq_pc.size() > 0)};
    e.mon = {m_pc, m_op, m_cls};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit en = 1);
    for (int i = 0; i < n; i++) cyc(1, en, 0, 0, 0, 0, 0);
  endtask

  task automatic iss(input bit [31:0] pc, input bit [31:0] ins, input bit rv = 0, input bit fl = 0);
    cyc(1, 1, 1, pc, ins, rv, fl);
  endtask

  // scoreboard monitor: pops one expected snapshot for every clocked DUT output set
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({instr_start, instr_active, instr_done, instr_abort, instr_timeout, err_overlap, busy} !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl @%0t: got start/active/done/abort/timeout/err/busy=%b expected %b", $time,
                   {instr_start, instr_active, instr_done, instr_abort, instr_timeout, err_overlap, busy}, e.ctl);
        end
        n_checks++;
        if ({mon_pc, mon_opcode, mon_class} !== e.mon) begin
          n_fail++;
          $display("FAIL mon @%0t: got pc=%h op=%h class=%0d expected pc=%h op=%h class=%0d", $time,
                   mon_pc, mon_opcode, mon_class, e.mon[41:10], e.mon[9:3], e.mon[2:0]);
        end
        n_checks++;
        if (instr_start === 1'b1 && instr_done === 1'b1) begin
          n_fail++;
          $display("FAIL start_done_overlap @%0t: got start=1 done=1 expected not both", $time);
        end
      end
    end
  end

  initial begin
    bit [31:0] ins;
    bit [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h73, 7'h37, 7'h0f};
    #1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // plain issue then retire 4 cycles later
    iss(32'h100, 32'h00A00093); idle(3); cyc(1, 1, 0, 0, 0, 1, 0); idle(3);
    // issue and retire in the same idle cycle
    iss(32'h108, 32'h00000013, 1); idle(3);
    // back-to-back retire+issue of a MUL
    iss(32'h200, 32'h00000033); idle(2); iss(32'h204, 32'h02208033, 1); idle(1);
    cyc(1, 1, 0, 0, 0, 1, 0); idle(3);
    // timeout
    iss(32'h300, 32'h00002003); idle(20);
    // flush with retire and issue, then overlap
    iss(32'h400, 32'h00000063); idle(2); iss(32'h404, 32'h0000006f, 1, 1); idle(3);
    iss(32'h500, 32'h00000023); idle(1); iss(32'h504, 32'h00000073); cyc(1, 1, 0, 0, 0, 1, 0); idle(3);
    // issue in the DONE cycle
    iss(32'h580, 32'h00000067); cyc(1, 1, 0, 0, 0, 1, 0); iss(32'h584, 32'h00000037);
    idle(1); cyc(1, 1, 0, 0, 0, 1, 0); idle(2);
    // reset mid-instruction, then disabled monitor
    iss(32'h600, 32'h02000033); idle(2); cyc(0, 1, 0, 0, 0, 0, 0); idle(2);
    cyc(1, 0, 1, 32'h700, 32'h00000033, 0, 0); idle(3, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(9)];
      if (ins[6:0] == 7'h13) ins[25] = 1'b0;
      if (ins[6:0] == 7'h33 && $urandom_range(1) == 1) ins[31:25] = 7'b0000001;
      cyc(($urandom_range(99) != 0), ($urandom_range(9) != 0), ($urandom_range(99) < 30),
          $urandom, ins, ($urandom_range(99) < 20), ($urandom_range(99) < 4));
    end
    idle(3);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
